cam_capture_px: RTL and testbench

- Parametrised pixel-capture front end for an 8-bit parallel camera bus (OV7670-style: p_clock, vsync, href, p_data).
- Pairs bytes into pixels and converts each pixel to an 8-bit stored format: RGB332 from RGB565, or luma from YUV422.
- Generates a linear frame-buffer write address, flags overflow and reports frame completion.
- Sits between the camera pins and the frame-buffer RAM write port, in the p_clock domain.

---
 rtl/cam_capture_px.sv | 145 ++++++++++++++
 tb/tb_cam_capture_px.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_capture_px.sv
// Pixel-capture front end for an 8-bit parallel camera bus: pairs bytes into pixels,
// converts them to an 8-bit stored format and generates linear frame-buffer write addresses.
module cam_capture_px #(
  parameter int unsigned H_RES  = 160,
  parameter int unsigned V_RES  = 120,
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned FCNT_W = 8
) (
  input  logic              p_clock,
  input  logic              rst,
  input  logic              enable,
  input  logic              mode,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        p_data,
  output logic [7:0]        pixel_data,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              pixel_valid,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              capturing,
  output logic              overflow
);

  localparam int unsigned XW = $clog2(H_RES + 1);
  localparam int unsigned YW = $clog2(V_RES + 1);

  localparam logic [XW-1:0]     HLimit   = XW'(H_RES);
  localparam logic [YW-1:0]     VLimit   = YW'(V_RES);
  localparam logic [ADDR_W-1:0] LineStep = ADDR_W'(H_RES);

  typedef enum logic [1:0] {StIdle, StWaitHi, StWaitLo, StCapture} state_e;

  state_e state_q, state_d;

  logic              vsync_d, href_d;
  logic              phase_q;
  logic [7:0]        b1_q;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic [ADDR_W-1:0] line_base_q;
  logic              mode_q;

  logic vsync_rise, vsync_fall;
  logic frame_start, frame_end;
  logic pix_store;
  logic [7:0] pix_conv;

  assign vsync_rise = vsync & ~vsync_d;
  assign vsync_fall = ~vsync & vsync_d;

  // State register
  always_ff @(posedge p_clock) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; arming only waits for a full vsync high/low cycle so a
  // partial frame is never captured.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (enable) state_d = StWaitHi;
      StWaitHi:  if (vsync) state_d = StWaitLo;
      StWaitLo:  if (vsync_fall) state_d = StCapture;
      StCapture: if (vsync_rise) state_d = enable ? StWaitLo : StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    capturing   = (state_q == StCapture);
    frame_start = (state_q == StWaitLo) && vsync_fall;
    frame_end   = (state_q == StCapture) && vsync_rise;
  end

  assign pix_store = (x_q < HLimit) && (y_q < VLimit);
  assign pix_conv  = mode_q ? b1_q : {b1_q[7:5], b1_q[2:0], p_data[4:3]};

  always_ff @(posedge p_clock) begin
    if (rst) begin
      vsync_d     <= 1'b0;
      href_d      <= 1'b0;
      phase_q     <= 1'b0;
      b1_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      line_base_q <= '0;
      mode_q      <= 1'b0;
      pixel_data  <= '0;
      pixel_addr  <= '0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      frame_cnt   <= '0;
      overflow    <= 1'b0;
    end else begin
      vsync_d     <= vsync;
      href_d      <= href;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;

      if (frame_start) begin
        x_q         <= '0;
        y_q         <= '0;
        line_base_q <= '0;
        phase_q     <= 1'b0;
        overflow    <= 1'b0;
        mode_q      <= mode;
      end else if (capturing) begin
        if (href) begin
          phase_q <= ~phase_q;
          if (!phase_q) begin
            b1_q <= p_data;
          end else if (pix_store) begin
            pixel_valid <= 1'b1;
            pixel_data  <= pix_conv;
            pixel_addr  <= line_base_q + ADDR_W'(x_q);
            x_q         <= x_q + 1'b1;
          end else begin
            // Pixel beyond the stored window: drop it, x stays saturated.
            overflow <= 1'b1;
          end
        end else begin
          phase_q <= 1'b0;
          // Empty lines (no stored pixel) do not consume a frame-buffer row.
          if (href_d && (x_q != '0)) begin
            y_q         <= y_q + 1'b1;
            line_base_q <= line_base_q + LineStep;
            x_q         <= '0;
          end
        end

        if (frame_end) begin
          frame_done <= 1'b1;
          frame_cnt  <= frame_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_capture_px.sv
// Directed bench for cam_capture_px: a scoreboard queue holds expected pixel writes,
// popped and compared whenever the DUT strobes pixel_valid.
module tb_cam_capture_px;

  localparam int unsigned H_RES  = 4;
  localparam int unsigned V_RES  = 3;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned FCNT_W = 2;

  logic              p_clock;
  logic              rst;
  logic              enable;
  logic              mode;
  logic              vsync;
  logic              href;
  logic [7:0]        p_data;
  logic [7:0]        pixel_data;
  logic [ADDR_W-1:0] pixel_addr;
  logic              pixel_valid;
  logic              frame_done;
  logic [FCNT_W-1:0] frame_cnt;
  logic              capturing;
  logic              overflow;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } px_t;

  px_t sb[$];
  px_t exp_px;
  int  n_tests  = 0;
  int  n_fail   = 0;
  int  done_cnt = 0;

  cam_capture_px #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .ADDR_W(ADDR_W),
    .FCNT_W(FCNT_W)
  ) dut (
    .p_clock    (p_clock),
    .rst        (rst),
    .enable     (enable),
    .mode       (mode),
    .vsync      (vsync),
    .href       (href),
    .p_data     (p_data),
    .pixel_data (pixel_data),
    .pixel_addr (pixel_addr),
    .pixel_valid(pixel_valid),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .capturing  (capturing),
    .overflow   (overflow)
  );

  initial p_clock = 1'b0;
  always #5 p_clock = ~p_clock;

  function automatic logic [7:0] rgb332(input logic [7:0] b1, input logic [7:0] b2);
    return {b1[7:5], b1[2:0], b2[4:3]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge p_clock);
      #1;
    end
  endtask

  task automatic expect_px(input int first, input int n, input logic [7:0] d);
    px_t p;
    for (int i = 0; i < n; i++) begin
      p.addr = ADDR_W'(first + i);
      p.data = d;
      sb.push_back(p);
    end
  endtask

  task automatic send_line(input int nbytes, input logic [7:0] b1, input logic [7:0] b2);
    for (int i = 0; i < nbytes; i++) begin
      href   = 1'b1;
      p_data = (i % 2 == 1) ? b2 : b1;
      tick();
    end
    href   = 1'b0;
    p_data = 8'h00;
    tick(2);
  endtask

  // vsync high then low: ends a running frame, then starts the next one if armed.
  task automatic frame_gap();
    href  = 1'b0;
    vsync = 1'b1;
    tick(3);
    vsync = 1'b0;
    tick(2);
  endtask

  // Scoreboard monitor, sampled on the falling edge away from DUT updates.
  always @(negedge p_clock) begin
    if (frame_done) done_cnt++;
    if (pixel_valid) begin
      n_tests++;
      assert (sb.size() != 0)
      else begin
        n_fail++;
        $error("FAIL unexpected_strobe: observed addr %0h data %0h expected no strobe",
               pixel_addr, pixel_data);
      end
      if (sb.size() != 0) begin
        exp_px = sb.pop_front();
        check("pix_addr", 32'(pixel_addr), 32'(exp_px.addr));
        check("pix_data", 32'(pixel_data), 32'(exp_px.data));
      end
    end
  end

  initial begin
    logic [7:0] yuv [4];
    yuv = '{8'h80, 8'h11, 8'h90, 8'h22};

    rst = 1'b1; enable = 1'b0; mode = 1'b0; vsync = 1'b0; href = 1'b0; p_data = 8'h00;
    tick(3);
    check("rst_valid", 32'(pixel_valid), 0);
    check("rst_done", 32'(frame_done), 0);
    check("rst_fcnt", 32'(frame_cnt), 0);
    check("rst_capturing", 32'(capturing), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_addr", 32'(pixel_addr), 0);
    check("rst_data", 32'(pixel_data), 0);

    // Start alignment: released mid-frame with href active, nothing may be captured.
    href = 1'b1; p_data = 8'h55;
    tick();
    rst = 1'b0; enable = 1'b1;
    send_line(8, 8'hF8, 8'h1F);
    send_line(8, 8'hF8, 8'h1F);
    check("align_capturing", 32'(capturing), 0);
    frame_gap();
    check("align_started", 32'(capturing), 1);

    // Basic frame
    expect_px(0, 12, 8'hE3);
    repeat (3) send_line(8, 8'hF8, 8'h1F);
    check("basic_overflow", 32'(overflow), 0);
    check("basic_pending", 32'(sb.size()), 0);
    frame_gap();
    check("basic_done", 32'(done_cnt), 1);
    check("basic_fcnt", 32'(frame_cnt), 1);

    // Overflow: long first line, then more lines than V_RES
    expect_px(0, 4, rgb332(8'h2A, 8'h18));
    send_line(12, 8'h2A, 8'h18);
    expect_px(4, 4, rgb332(8'hC3, 8'h08));
    send_line(8, 8'hC3, 8'h08);
    expect_px(8, 4, rgb332(8'h3C, 8'hF0));
    send_line(8, 8'h3C, 8'hF0);
    send_line(8, 8'hFF, 8'hFF);
    send_line(8, 8'hFF, 8'hFF);
    check("ovf_set", 32'(overflow), 1);
    check("ovf_pending", 32'(sb.size()), 0);
    frame_gap();
    check("ovf_done", 32'(done_cnt), 2);
    check("ovf_fcnt", 32'(frame_cnt), 2);
    check("ovf_cleared", 32'(overflow), 0);

    // Odd and empty lines
    expect_px(0, 3, rgb332(8'h47, 8'hA5));
    send_line(7, 8'h47, 8'hA5);
    send_line(1, 8'h12, 8'h34);
    expect_px(4, 4, rgb332(8'h66, 8'h99));
    send_line(8, 8'h66, 8'h99);
    check("odd_overflow", 32'(overflow), 0);
    check("odd_pending", 32'(sb.size()), 0);
    mode = 1'b1;
    frame_gap();
    check("odd_done", 32'(done_cnt), 3);

    // Mode 1: mode changed mid-frame must not take effect
    mode = 1'b0;
    expect_px(0, 1, 8'h80);
    expect_px(1, 1, 8'h90);
    for (int i = 0; i < 4; i++) begin
      href = 1'b1; p_data = yuv[i];
      tick();
    end
    href = 1'b0;
    tick(2);
    expect_px(4, 2, 8'hF8);
    send_line(4, 8'hF8, 8'h1F);
    check("yuv_pending", 32'(sb.size()), 0);
    frame_gap();
    check("yuv_done", 32'(done_cnt), 4);
    check("fcnt_wrap", 32'(frame_cnt), 0);

    // Disarm mid-frame: frame still completes, then IDLE
    expect_px(0, 2, 8'hE3);
    send_line(4, 8'hF8, 8'h1F);
    enable = 1'b0;
    expect_px(4, 4, 8'hE3);
    send_line(8, 8'hF8, 8'h1F);
    frame_gap();
    check("disarm_done", 32'(done_cnt), 5);
    check("disarm_fcnt", 32'(frame_cnt), 1);
    check("disarm_idle", 32'(capturing), 0);
    send_line(8, 8'hF8, 8'h1F);
    frame_gap();
    send_line(8, 8'hF8, 8'h1F);
    check("disarm_still_idle", 32'(capturing), 0);
    check("disarm_no_done", 32'(done_cnt), 5);
    check("disarm_pending", 32'(sb.size()), 0);

    // Reset mid-frame
    enable = 1'b1;
    frame_gap();
    check("rearm_capturing", 32'(capturing), 1);
    expect_px(0, 2, 8'hE3);
    send_line(4, 8'hF8, 8'h1F);
    rst = 1'b1;
    tick(2);
    rst = 1'b0; enable = 1'b0;
    check("midrst_fcnt", 32'(frame_cnt), 0);
    check("midrst_capturing", 32'(capturing), 0);
    check("midrst_valid", 32'(pixel_valid), 0);
    frame_gap();
    check("midrst_no_done", 32'(done_cnt), 5);
    check("final_pending", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
